count_capture_compare: RTL and testbench
========================================

Name: count_capture_compare

Overview:
- Downstream consumer of the 8-bit ripple counter output.
- Samples the counter value, which is asynchronous and may be mid-ripple, into the CLK domain and accepts only stable values.
- Compares the accepted count against a double-buffered compare register.
- Produces a match pulse, a wrap pulse, a PWM level and a sticky match flag for the arithmetic unit's control logic.

Parameters:
- WIDTH, 8, width of count and compare values.
- CMP_RST, 0, reset value of the active compare register.

Ports:
- CLK  in  1  system clock; all state is updated on the rising edge.
- RST  in  1  asynchronous active-low reset.
- CNT_IN  in  WIDTH  raw counter value (Q of the counter); may glitch while rippling.
- CMP_VAL  in  WIDTH  new compare value.
- CMP_WR  in  1  compare load request.
- CMP_BUSY  out  1  a shadow value is pending; further CMP_WR is ignored.
- CMP_ACK  out  1  one-cycle pulse when the shadow value is transferred to active.
- CLR_FLAG  in  1  clears FLAG.
- CNT_OUT  out  WIDTH  last accepted stable count.
- CNT_VALID  out  1  at least one count has been accepted since reset.
- UPD  out  1  one-cycle pulse when CNT_OUT changed this edge.
- MATCH  out  1  one-cycle pulse: the new CNT_OUT equals the active compare value.
- WRAP  out  1  one-cycle pulse: the new CNT_OUT is less than the previous CNT_OUT.
- PWM  out  1  registered: CNT_OUT < active compare value.
- FLAG  out  1  sticky, set by MATCH.

Behaviour:
- Reset (RST=0, asynchronous):
  - s1, s2, CNT_OUT, shadow, CMP_BUSY, CMP_ACK, CNT_VALID, UPD, MATCH, WRAP, PWM and FLAG all go to 0.
  - Active compare register goes to CMP_RST.
  - Reset asserted mid-operation discards any pending shadow value without ACK.
- Sampling:
  - Each edge: s1 <= CNT_IN; s2 <= s1.
  - A value is accepted when s1 == s2.
  - Accepted value drives CNT_OUT at the next edge. Latency from a stable CNT_IN to CNT_OUT is 3 edges.
  - If s1 != s2, CNT_OUT holds and no pulses fire.
- Update event: acceptance where CNT_VALID=0 or s2 != CNT_OUT.
  - On the event: CNT_OUT <= s2, UPD=1, CNT_VALID <= 1.
  - Re-accepting an unchanged value produces no UPD.
- WRAP: update event with CNT_VALID=1 and s2 < CNT_OUT. This covers 255->0 and an external counter reset. The first accept after reset never wraps.
- Compare load handshake:
  - CMP_WR=1 with CMP_BUSY=0: shadow <= CMP_VAL, CMP_BUSY <= 1.
  - CMP_WR=1 with CMP_BUSY=1: ignored.
  - Transfer (active <= shadow, CMP_BUSY <= 0, CMP_ACK=1 for one cycle) happens on the edge of a WRAP event, or on the first update event while CNT_VALID=0.
  - CMP_WR in the same cycle as a WRAP, with BUSY=0: the value loads into the shadow and transfers at the following wrap, not this one.
- MATCH, PWM and FLAG:
  - MATCH and PWM are evaluated against the active value in effect after this edge, including a same-edge transfer.
  - MATCH = update event and s2 == active_next.
  - PWM <= (s2 < active_next) on update events; otherwise holds.
  - Boundaries: active=0 gives PWM constant 0. Active=255 gives PWM=1 except at count 255.
- FLAG:
  - FLAG <= 1 on MATCH.
  - FLAG <= 0 on CLR_FLAG.
  - MATCH and CLR_FLAG in the same cycle: set wins.
- Arithmetic: all comparisons are unsigned, WIDTH bits. No wrap arithmetic beyond compare.

Decomposition:
- Shared package holds:
  - WIDTH default (8).
  - CMP_RST default.
  - Count all-ones constant, used in tests.
- One sub-module: stable_sampler (WIDTH).
  - Contains s1/s2 and the equality check.
  - Outputs sampled value plus an accept strobe.
  - Reusable for other asynchronous ripple outputs.
- Compare, handshake and flag logic stay in the top module.

Test Plan:
- Reset then hold CNT_IN=5 → CNT_OUT=5, UPD=1, CNT_VALID=1 at 3rd edge. WRAP=0. PWM=0 (active=0).
- CNT_IN alternates 3/4 every cycle (unstable) → CNT_OUT unchanged, UPD=0. Then hold 4 → CNT_OUT=4 after 3 edges.
- CMP_WR with CMP_VAL=10, count steps 250..255,0 → BUSY=1 until 255->0. On that edge: WRAP=1, CMP_ACK=1, BUSY=0, PWM=1. At count 10: MATCH=1, FLAG=1, PWM=0.
- Second CMP_WR (CMP_VAL=20) while BUSY → ignored. After the wrap, active=10, not 20.
- CLR_FLAG asserted in the same cycle as MATCH → FLAG stays 1. CLR_FLAG alone next cycle → FLAG=0.
- RST low mid-count with shadow pending → all outputs 0 immediately, BUSY=0, no ACK. Active=CMP_RST. First post-reset accept gives no WRAP.

Source files
------------

// File: rtl/count_capture_compare_pkg.sv
// Shared constants for the ripple-counter capture/compare block and its sampler.
package count_capture_compare_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_CMP_RST = 0;

  localparam logic [DEF_WIDTH-1:0] CNT_ONES = '1;

endpackage

// File: rtl/count_capture_compare_stable_sampler.sv
// Two-stage sampler for an asynchronous, possibly rippling bus; flags a value
// as acceptable once two consecutive samples agree.
module count_capture_compare_stable_sampler
  import count_capture_compare_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sample,
  output logic             accept_c
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= '0;
      sample <= '0;
    end else begin
      s1     <= din;
      sample <= s1;
    end
  end

  // sample is the older stage; equal stages mean no ripple was caught
  assign accept_c = (s1 == sample);

endmodule

// File: rtl/count_capture_compare.sv
// Captures a stable ripple-counter value and compares it against a
// double-buffered compare register, producing match/wrap pulses, PWM and a flag.
module count_capture_compare
  import count_capture_compare_pkg::*;
#(
  parameter int unsigned         WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0]    CMP_RST = WIDTH'(DEF_CMP_RST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             cmp_wr,
  output logic             cmp_busy,
  output logic             cmp_ack,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             upd,
  output logic             match,
  output logic             wrap,
  output logic             pwm,
  output logic             flag
);

  logic [WIDTH-1:0] s2;
  logic             accept_c;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] active_nxt_c;
  logic             upd_ev_c;
  logic             wrap_ev_c;
  logic             xfer_c;
  logic             load_c;
  logic             match_c;

  count_capture_compare_stable_sampler #(
    .WIDTH (WIDTH)
  ) u_stable_sampler (
    .clk      (clk),
    .rst      (rst),
    .din      (cnt_in),
    .sample   (s2),
    .accept_c (accept_c)
  );

  // Event decode; compare uses the active value as it will be after this edge
  always_comb begin
    upd_ev_c     = accept_c && (!cnt_valid || (s2 != cnt_out));
    wrap_ev_c    = upd_ev_c && cnt_valid && (s2 < cnt_out);
    xfer_c       = cmp_busy && (wrap_ev_c || (upd_ev_c && !cnt_valid));
    load_c       = cmp_wr && !cmp_busy;
    active_nxt_c = xfer_c ? shadow_q : active_q;
    match_c      = upd_ev_c && (s2 == active_nxt_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q  <= '0;
      active_q  <= CMP_RST;
      cmp_busy  <= 1'b0;
      cmp_ack   <= 1'b0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      upd       <= 1'b0;
      match     <= 1'b0;
      wrap      <= 1'b0;
      pwm       <= 1'b0;
      flag      <= 1'b0;
    end else begin
      if (load_c) begin
        shadow_q <= cmp_val;
      end
      cmp_busy <= load_c || (cmp_busy && !xfer_c);
      cmp_ack  <= xfer_c;
      active_q <= active_nxt_c;
      upd      <= upd_ev_c;
      wrap     <= wrap_ev_c;
      match    <= match_c;
      if (upd_ev_c) begin
        cnt_out   <= s2;
        cnt_valid <= 1'b1;
        pwm       <= (s2 < active_nxt_c);
      end
      // a same-cycle match overrides the clear request
      if (match_c) begin
        flag <= 1'b1;
      end else if (clr_flag) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_capture_compare.sv
// Directed bench for count_capture_compare with a per-cycle reference model.
module tb_count_capture_compare;
  import count_capture_compare_pkg::*;

  localparam int unsigned W = DEF_WIDTH;

  logic         clk;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic [W-1:0] cmp_val;
  logic         cmp_wr;
  logic         cmp_busy;
  logic         cmp_ack;
  logic         clr_flag;
  logic [W-1:0] cnt_out;
  logic         cnt_valid;
  logic         upd;
  logic         match;
  logic         wrap;
  logic         pwm;
  logic         flag;

  int checks;
  int fails;

  count_capture_compare #(
    .WIDTH   (W),
    .CMP_RST (W'(DEF_CMP_RST))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cmp_val   (cmp_val),
    .cmp_wr    (cmp_wr),
    .cmp_busy  (cmp_busy),
    .cmp_ack   (cmp_ack),
    .clr_flag  (clr_flag),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .upd       (upd),
    .match     (match),
    .wrap      (wrap),
    .pwm       (pwm),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: history of sampled inputs, accepted when the last two agree
  logic [W-1:0] hist[$];
  logic [W-1:0] m_cnt, m_active, m_shadow;
  bit m_valid, m_pend, m_upd, m_wrap, m_match, m_ack, m_pwm, m_flag;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      hist = '{W'(0), W'(0)};
      m_cnt = '0; m_active = W'(DEF_CMP_RST); m_shadow = '0;
      m_valid = 0; m_pend = 0; m_upd = 0; m_wrap = 0;
      m_match = 0; m_ack = 0; m_pwm = 0; m_flag = 0;
    end else begin
      logic [W-1:0] v;
      bit first, xfer;
      first = !m_valid;
      m_upd = 0; m_wrap = 0; m_match = 0; m_ack = 0;
      v = hist[1];
      if (hist[0] == hist[1] && (first || v != m_cnt)) begin
        m_upd  = 1;
        m_wrap = !first && (v < m_cnt);
      end
      xfer = m_pend && (m_wrap || (m_upd && first));
      if (xfer) begin
        m_active = m_shadow; m_pend = 0; m_ack = 1;
      end else if (cmp_wr && !m_pend) begin
        m_shadow = cmp_val; m_pend = 1;
      end
      if (m_upd) begin
        m_match = (v == m_active);
        m_pwm   = (v < m_active);
        m_cnt   = v;
        m_valid = 1;
      end
      if (m_match) m_flag = 1;
      else if (clr_flag) m_flag = 0;
      hist.push_back(cnt_in);
      void'(hist.pop_front());
    end
  end

  // Every falling edge, all outputs against the model
  initial forever begin
    @(negedge clk);
    chk("cnt_out",   cnt_out,   m_cnt);
    chk("cnt_valid", cnt_valid, W'(m_valid));
    chk("upd",       upd,       W'(m_upd));
    chk("wrap",      wrap,      W'(m_wrap));
    chk("match",     match,     W'(m_match));
    chk("pwm",       pwm,       W'(m_pwm));
    chk("flag",      flag,      W'(m_flag));
    chk("cmp_busy",  cmp_busy,  W'(m_pend));
    chk("cmp_ack",   cmp_ack,   W'(m_ack));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  initial begin
    logic [W-1:0] alt [4];
    checks = 0; fails = 0;
    rst = 1'b1; cnt_in = W'(5); cmp_val = '0; cmp_wr = 1'b0; clr_flag = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_cnt_out", cnt_out, 0);
    chk("rst_valid", cnt_valid, 0);
    chk("rst_busy", cmp_busy, 0);
    chk("rst_pwm", pwm, 0);
    tick(); tick();
    rst = 1'b1;

    // Stable 5 reaches cnt_out on the 3rd edge
    hold(W'(5), 3);
    chk("s1_cnt_out", cnt_out, 5);
    chk("s1_upd", upd, 1);
    chk("s1_valid", cnt_valid, 1);
    chk("s1_wrap", wrap, 0);
    chk("s1_pwm", pwm, 0);

    // Unstable 3/4 input must be ignored
    alt = '{W'(4), W'(3), W'(4), W'(3)};
    clr_flag = 1'b1;
    foreach (alt[i]) begin
      cnt_in = alt[i];
      tick();
      clr_flag = 1'b0;
      chk("s2_hold_cnt", cnt_out, 5);
      chk("s2_no_upd", upd, 0);
    end
    chk("s2_flag_clr", flag, 0);
    hold(W'(4), 2);
    chk("s2_not_yet", cnt_out, 5);
    tick();
    chk("s2_cnt_out", cnt_out, 4);
    chk("s2_upd", upd, 1);
    chk("s2_wrap_down", wrap, 1);

    // Compare load, ignored second write, transfer on 255->0
    cmp_val = W'(10); cmp_wr = 1'b1; cnt_in = W'(250);
    tick();
    cmp_wr = 1'b0;
    chk("s3_busy", cmp_busy, 1);
    hold(W'(250), 2);
    for (int v = 251; v <= 255; v++) begin
      if (v == 253) begin
        cmp_val = W'(20); cmp_wr = 1'b1; cnt_in = W'(v);
        tick();
        cmp_wr = 1'b0;
        hold(W'(v), 2);
      end else begin
        hold(W'(v), 3);
      end
    end
    chk("s3_cnt_ff", cnt_out, CNT_ONES);
    chk("s3_busy_ff", cmp_busy, 1);
    hold(W'(0), 3);
    chk("s3_cnt_0", cnt_out, 0);
    chk("s3_wrap", wrap, 1);
    chk("s3_ack", cmp_ack, 1);
    chk("s3_busy_done", cmp_busy, 0);
    chk("s3_pwm_hi", pwm, 1);
    for (int v = 1; v <= 9; v++) hold(W'(v), 3);
    chk("s3_flag_pre", flag, 0);
    chk("s3_pwm_9", pwm, 1);
    hold(W'(10), 2);
    clr_flag = 1'b1;
    tick();
    chk("s3_match", match, 1);
    chk("s3_flag_set_wins", flag, 1);
    chk("s3_pwm_lo", pwm, 0);
    tick();
    clr_flag = 1'b0;
    chk("s3_flag_cleared", flag, 0);
    chk("s3_no_pending", cmp_busy, 0);

    // Reset with a pending shadow value
    cmp_val = W'(30); cmp_wr = 1'b1; cnt_in = W'(12);
    tick();
    cmp_wr = 1'b0;
    chk("s4_busy", cmp_busy, 1);
    tick();
    #1 rst = 1'b0;
    #1;
    chk("s4_rst_cnt", cnt_out, 0);
    chk("s4_rst_busy", cmp_busy, 0);
    chk("s4_rst_ack", cmp_ack, 0);
    chk("s4_rst_valid", cnt_valid, 0);
    chk("s4_rst_upd", upd, 0);
    tick();
    rst = 1'b1;
    cnt_in = W'(200);
    tick();
    chk("s4_first_cnt", cnt_out, 0);
    chk("s4_first_upd", upd, 1);
    chk("s4_first_nowrap", wrap, 0);
    chk("s4_first_match", match, 1);
    chk("s4_first_noack", cmp_ack, 0);
    cmp_val = CNT_ONES; cmp_wr = 1'b1;
    tick();
    cmp_wr = 1'b0;
    tick();
    chk("s4_cnt_200", cnt_out, 200);
    chk("s4_nowrap_up", wrap, 0);
    chk("s4_busy_255", cmp_busy, 1);
    chk("s4_pwm_act0", pwm, 0);
    hold(W'(0), 3);
    chk("s4_ack", cmp_ack, 1);
    chk("s4_pwm_0", pwm, 1);
    hold(CNT_ONES, 3);
    chk("s4_match_ff", match, 1);
    chk("s4_pwm_ff", pwm, 0);
    hold(W'(7), 3);
    chk("s4_wrap_7", wrap, 1);
    chk("s4_pwm_7", pwm, 1);
    chk("s4_noack_7", cmp_ack, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
